// File: rtl/idct_2d_8x8.sv
// 8x8 two-pass inverse DCT: load 64 coefficients, row pass, column pass,
// then stream 64 reconstructed samples in row-major order.
module idct_2d_8x8 #(
    parameter int DATA_WIDTH     = 16,
    parameter int INTERNAL_WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         data_in_valid,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int ACC_W = INTERNAL_WIDTH + 13;

    localparam logic signed [ACC_W-1:0] R_MAX =
        ACC_W'({(INTERNAL_WIDTH-1){1'b1}});
    localparam logic signed [ACC_W-1:0] R_MIN = ~R_MAX;
    localparam logic signed [ACC_W-1:0] D_MAX =
        ACC_W'({(DATA_WIDTH-1){1'b1}});
    localparam logic signed [ACC_W-1:0] D_MIN = ~D_MAX;

    typedef enum logic [2:0] {
        IDLE, LOAD, ROW, COL, OUT, DONE
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    logic signed [DATA_WIDTH-1:0]     x_mem [64];
    logic signed [INTERNAL_WIDTH-1:0] r_mem [64];
    logic signed [DATA_WIDTH-1:0]     p_mem [64];

    logic signed [DATA_WIDTH-1:0] data_out_q;
    logic                         valid_q, busy_q, done_q;

    // 128*c(k)*cos((2n+1)k*pi/16), folded onto the first quarter wave
    function automatic logic signed [9:0] coef(input int n, input int k);
        int  m;
        int  v;
        logic neg;
        m   = ((2 * n + 1) * k) % 32;
        neg = 1'b0;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        case (m)
            0:       v = 128;
            1:       v = 126;
            2:       v = 118;
            3:       v = 106;
            4:       v = 91;
            5:       v = 71;
            6:       v = 49;
            7:       v = 25;
            default: v = 0;
        endcase
        if (k == 0) v = 91;
        return 10'(neg ? -v : v);
    endfunction

    logic signed [9:0] m_tab [8][8];

    always_comb begin
        for (int n = 0; n < 8; n++)
            for (int k = 0; k < 8; k++)
                m_tab[n][k] = coef(n, k);
    end

    logic [2:0] hi, lo;
    assign hi = cnt_q[5:3];
    assign lo = cnt_q[2:0];

    logic signed [ACC_W-1:0] prod [8];
    logic signed [ACC_W-1:0] s1   [4];
    logic signed [ACC_W-1:0] s2   [2];
    logic signed [ACC_W-1:0] acc, rnd;
    logic signed [ACC_W-1:0] opnd, cf;

    // Row pass: R[hi][lo]; column pass: P[hi][lo] from column lo of R
    always_comb begin
        opnd = '0;
        cf   = '0;
        for (int k = 0; k < 8; k++) begin
            if (state_q == ROW) begin
                opnd = ACC_W'(x_mem[{hi, 3'(k)}]);
                cf   = ACC_W'(m_tab[lo][k]);
            end else begin
                opnd = ACC_W'(r_mem[{3'(k), lo}]);
                cf   = ACC_W'(m_tab[hi][k]);
            end
            prod[k] = opnd * cf;
        end
        for (int i = 0; i < 4; i++) s1[i] = prod[2*i] + prod[2*i+1];
        for (int i = 0; i < 2; i++) s2[i] = s1[2*i] + s1[2*i+1];
        acc = s2[0] + s2[1];
        rnd = (acc + ACC_W'(128)) >>> 8;
    end

    logic signed [INTERNAL_WIDTH-1:0] r_sat;
    logic signed [DATA_WIDTH-1:0]     d_sat;

    always_comb begin
        if (rnd > R_MAX)      r_sat = R_MAX[INTERNAL_WIDTH-1:0];
        else if (rnd < R_MIN) r_sat = R_MIN[INTERNAL_WIDTH-1:0];
        else                  r_sat = rnd[INTERNAL_WIDTH-1:0];
        if (rnd > D_MAX)      d_sat = D_MAX[DATA_WIDTH-1:0];
        else if (rnd < D_MIN) d_sat = D_MIN[DATA_WIDTH-1:0];
        else                  d_sat = rnd[DATA_WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (data_in_valid) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) state_d = ROW;
                end
            end
            ROW: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) state_d = COL;
            end
            COL: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) state_d = OUT;
            end
            OUT: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) state_d = DONE;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == OUT);
            done_q  <= (state_d == DONE);
            busy_q  <= (state_d == LOAD) || (state_d == ROW) ||
                       (state_d == COL)  || (state_d == OUT);
            // Output register leads the OUT count so sample 0 appears on entry
            if (state_d == OUT) data_out_q <= p_mem[cnt_d];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == LOAD && data_in_valid) x_mem[cnt_q] <= data_in;
        if (state_q == ROW) r_mem[cnt_q] <= r_sat;
        if (state_q == COL) p_mem[cnt_q] <= d_sat;
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_idct_2d_8x8.sv
// Scoreboard bench for idct_2d_8x8: directed blocks, stalls, mid-run
// reset and a short random regression against a real-valued table model.
module tb_idct_2d_8x8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] data_in = '0;
    logic               data_in_valid = 1'b0;
    logic signed [15:0] data_out;
    logic               data_out_valid;
    logic               busy;
    logic               done;

    idct_2d_8x8 #(.DATA_WIDTH(16), .INTERNAL_WIDTH(24)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int M [8][8];
    int exp_q [$];
    logic signed [15:0] last_out = '0;

    function automatic void check(string name, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void push_const(int v);
        for (int i = 0; i < 64; i++) exp_q.push_back(v);
    endfunction

    function automatic void push_model(input int x [64]);
        longint s;
        int r [64];
        for (int u = 0; u < 8; u++)
            for (int n = 0; n < 8; n++) begin
                s = 128;
                for (int k = 0; k < 8; k++) s += M[n][k] * x[8*u+k];
                s = s >>> 8;
                if (s > 8388607) s = 8388607;
                if (s < -8388608) s = -8388608;
                r[8*u+n] = int'(s);
            end
        for (int y = 0; y < 8; y++)
            for (int n = 0; n < 8; n++) begin
                s = 128;
                for (int k = 0; k < 8; k++) s += M[y][k] * r[8*k+n];
                s = s >>> 8;
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                exp_q.push_back(int'(s));
            end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            last_out = '0;
        end else if (data_out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual=%0d required=none",
                         data_out);
            end else begin
                check("data_out", data_out, exp_q.pop_front());
            end
            last_out = data_out;
        end else begin
            check("hold", data_out, last_out);
        end
        if (rst_n && done) begin
            done_cnt++;
            check("done_valid", data_out_valid, 0);
            check("done_busy", busy, 0);
        end
    end

    task automatic load_block(input int x [64], input bit stall);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_load", busy, 1);
        for (int i = 0; i < 64; i++) begin
            data_in = 16'(x[i]);
            data_in_valid = 1'b1;
            @(posedge clk); #1;
            if (stall && i != 63) begin
                data_in_valid = 1'b0;
                data_in = 16'h5a5a;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        data_in_valid = 1'b0;
    endtask

    task automatic finish_block(input bit junk);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (k < 200 && !seen) begin
            if (junk && k < 5) begin
                data_in_valid = 1'b1;
                data_in = 16'($urandom);
                start = 1'b1;
            end else begin
                data_in_valid = 1'b0;
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (data_out_valid) seen = 1'b1;
        end
        data_in_valid = 1'b0;
        start = 1'b0;
        check("latency", k, 128);
        k = 0;
        while (k < 100 && !done) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", done, 1);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int x [64];
        int y [64];
        int blocks;
        real pi;
        real c;
        real v;
        pi = 3.14159265358979;
        for (int n = 0; n < 8; n++)
            for (int k = 0; k < 8; k++) begin
                c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                v = 128.0 * c * $cos((2 * n + 1) * k * pi / 16.0);
                M[n][k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end

        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        blocks = 0;

        foreach (x[i]) x[i] = 0;
        push_const(0);
        load_block(x, 1'b0);
        finish_block(1'b0);
        blocks++;

        x[0] = 64;
        push_const(8);
        load_block(x, 1'b0);
        finish_block(1'b0);
        blocks++;

        x[0] = 32767;
        push_const(4141);
        load_block(x, 1'b0);
        finish_block(1'b0);
        blocks++;

        foreach (y[i]) y[i] = int'($urandom_range(0, 4095)) - 2048;
        push_model(y);
        load_block(y, 1'b0);
        finish_block(1'b0);
        push_model(y);
        load_block(y, 1'b1);
        finish_block(1'b1);
        blocks += 2;

        x[0] = 64;
        load_block(x, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_valid", data_out_valid, 0);
        check("abort_data", data_out, 0);
        check("abort_done", done, 0);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        push_const(8);
        load_block(x, 1'b0);
        finish_block(1'b0);
        blocks++;

        for (int b = 0; b < 30; b++) begin
            foreach (y[i]) y[i] = int'($urandom_range(0, 4095)) - 2048;
            push_model(y);
            load_block(y, 1'b0);
            finish_block(1'b0);
            blocks++;
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_cnt, blocks);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
